// File: rtl/serial_subtractor_sf_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_sf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-bit operand; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_sf.sv
// Single-bit full subtractor built from gate primitives: d = x - y - bin, bo = borrow out.
module full_subtractor_sf (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic xy;
    logic nx;
    logic nxy;
    logic t0;
    logic t1;

    xor g_x0 (xy, x, y);
    xor g_x1 (d, xy, bin);
    not g_n0 (nx, x);
    not g_n1 (nxy, xy);
    and g_a0 (t0, nx, y);
    and g_a1 (t1, nxy, bin);
    or  g_o0 (bo, t0, t1);

endmodule

// File: rtl/serial_subtractor_sf.sv
// Bit-serial unsigned subtractor (LSB first, one full-subtractor cell, registered borrow).
// Optional signed-overflow output is enabled by defining SIGNED_OVF_EN.
module serial_subtractor_sf
    import serial_subtractor_sf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SIGNED_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    logic             bit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] r_shift;

    full_subtractor_sf u_fs (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (borrow_q),
        .d   (bit_d),
        .bo  (borrow_d)
    );

    // Result register plus the bit being produced this cycle.
    assign r_shift = {bit_d, r_q};

    // Outputs are loaded on the edge entering FIN so diff/bout are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
`ifdef SIGNED_OVF_EN
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_d;
                    r_q      <= r_shift[WIDTH-1:1];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= r_shift;
                        bout_q  <= borrow_d;
                        state_q <= ST_FIN;
`ifdef SIGNED_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_sf.sv
// Self-checking bench for serial_subtractor_sf (WIDTH=8): table vectors, corner sequences, random ops.
module tb_serial_subtractor_sf;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SIGNED_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_sf #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.diff = x - y;
        e.bout = (x < y);
        e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        return e;
    endfunction

    // Advance to the next falling edge and score any completed operation.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                $display("done @%0d: diff=%0d bout=%0d (exp diff=%0d bout=%0d)",
                         cyc, diff, bout, e.diff, e.bout);
                chk("diff", diff, e.diff);
                chk("bout", bout, e.bout);
`ifdef SIGNED_OVF_EN
                chk("ovf", ovf, e.ovf);
`endif
            end
        end
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 30 && done_cnt == base; i++) tick();
        chk("done_seen", done_cnt - base, 1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        int base;
        int drv;
        base  = done_cnt;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(e);
        drv   = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        wait_done(base);
        chk("latency", done_cyc - drv, 9);
        tick();
        chk("idle_after_fin", busy, 0);
    endtask

    vec_t         vecs[8];
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];

    initial begin
        exp_t e;
        int   base;
        int   k;
        int   prev;
        logic [W-1:0] x;
        logic [W-1:0] y;

        vecs[0] = '{8'd23,  8'd9,   8'd14,  1'b0, 1'b0};
        vecs[1] = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
        vecs[2] = '{8'd100, 8'd100, 8'd0,   1'b0, 1'b0};
        vecs[3] = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[5] = '{8'h05,  8'h03,  8'h02,  1'b0, 1'b0};
        vecs[6] = '{8'd1,   8'd2,   8'd255, 1'b1, 1'b0};
        vecs[7] = '{8'h7F,  8'h80,  8'hFF,  1'b1, 1'b1};
        bb_a[0] = 8'd200; bb_b[0] = 8'd45;
        bb_a[1] = 8'd17;  bb_b[1] = 8'd99;
        bb_a[2] = 8'd3;   bb_b[2] = 8'd3;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            e.diff = vecs[i].diff;
            e.bout = vecs[i].bout;
            e.ovf  = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, e);
            chk("diff_held", diff, vecs[i].diff);
        end

        // Abort mid-operation with a 3-cycle reset; the aborted result must never appear.
        run_op(8'd23, 8'd9, model(8'd23, 8'd9));
        base = done_cnt;
        a = 8'd77; b = 8'd12; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_no_done", done_cnt - base, 0);

        // Reset and start together: reset wins, nothing is accepted.
        base = done_cnt;
        rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        repeat (12) tick();
        chk("rst_start_no_done", done_cnt - base, 0);

        // Interference: start and operands toggle during SHIFT.
        base = done_cnt;
        a = 8'd50; b = 8'd7; start = 1'b1;
        sb.push_back(model(8'd50, 8'd7));
        tick();
        a = 8'd1; b = 8'd2;
        for (int i = 0; i < 30 && done_cnt == base; i++) begin
            tick();
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        chk("intf_done_seen", done_cnt - base, 1);
        repeat (15) tick();
        chk("intf_single_done", done_cnt - base, 1);
        chk("intf_idle", busy, 0);

        // Back-to-back: start held high across three operations.
        base = done_cnt;
        k = 0;
        prev = 0;
        a = bb_a[0]; b = bb_b[0]; start = 1'b1;
        sb.push_back(model(bb_a[0], bb_b[0]));
        for (int i = 0; i < 60 && done_cnt < base + 3; i++) begin
            tick();
            if (done_cnt > base + k) begin
                if (k > 0) chk("b2b_period", done_cyc - prev, 10);
                prev = done_cyc;
                k++;
                if (k < 3) begin
                    a = bb_a[k];
                    b = bb_b[k];
                    sb.push_back(model(bb_a[k], bb_b[k]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", done_cnt - base, 3);
        repeat (12) tick();
        chk("b2b_no_extra", done_cnt - base, 3);

        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            run_op(x, y, model(x, y));
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
